// File: rtl/al4s3b_fpga_wb_pkg.sv
// rtl/al4s3b_fpga_wb_pkg.sv - shared types and constants for the Wishbone decoder
package al4s3b_fpga_wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ERR_ACK = 2'd2,
    S_ST_ACK  = 2'd3
  } wb_state_e;

  localparam int STAT_CNT_W = 16;
  localparam int TOUT_CNT_W = 8;

  localparam logic [7:0] STAT_OFF_UNMAP = 8'h00;
  localparam logic [7:0] STAT_OFF_TOUT  = 8'h04;
  localparam logic [7:0] STAT_OFF_LAST  = 8'h08;

  localparam int LAST_ERR_TOUT_BIT = 31;
  localparam int LAST_ERR_ADR_W    = 17;

  function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/al4s3b_fpga_wb_status_regs.sv
// rtl/al4s3b_fpga_wb_status_regs.sv - error counters and last-error capture
module al4s3b_fpga_wb_status_regs
  import al4s3b_fpga_wb_pkg::*;
#(
  parameter int          APERWIDTH          = 17,
  parameter int          APERSIZE           = 10,
  parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBADFABAC
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 wr_i,
  input  logic                 unmap_err_i,
  input  logic                 tout_err_i,
  input  logic [APERWIDTH-1:0] err_adr_i,
  input  logic [APERSIZE-1:0]  off_i,
  output logic [31:0]          rd_dat_o
);

  logic [STAT_CNT_W-1:0] unmap_cnt_q;
  logic [STAT_CNT_W-1:0] tout_cnt_q;
  logic [31:0]           last_err_q;
  logic [31:0]           err_word;
  logic [APERSIZE-1:0]   word_off;
  logic                  clr;
  logic                  unused_off;

  assign word_off   = {off_i[APERSIZE-1:2], 2'b00};
  assign unused_off = ^off_i[1:0];
  assign clr        = wr_i && (word_off == APERSIZE'(STAT_OFF_UNMAP));

  always_comb begin
    err_word = '0;
    err_word[LAST_ERR_ADR_W-1:0] = LAST_ERR_ADR_W'(err_adr_i);
    err_word[LAST_ERR_TOUT_BIT]  = tout_err_i;
  end

  // A clear in the same cycle as an error discards that error.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      unmap_cnt_q <= '0;
      tout_cnt_q  <= '0;
      last_err_q  <= '0;
    end else if (clr) begin
      unmap_cnt_q <= '0;
      tout_cnt_q  <= '0;
      last_err_q  <= '0;
    end else begin
      if (unmap_err_i) unmap_cnt_q <= sat_inc(unmap_cnt_q);
      if (tout_err_i)  tout_cnt_q  <= sat_inc(tout_cnt_q);
      if (unmap_err_i || tout_err_i) last_err_q <= err_word;
    end
  end

  always_comb begin
    rd_dat_o = DEFAULT_READ_VALUE;
    if (word_off == APERSIZE'(STAT_OFF_UNMAP))      rd_dat_o = 32'(unmap_cnt_q);
    else if (word_off == APERSIZE'(STAT_OFF_TOUT))  rd_dat_o = 32'(tout_cnt_q);
    else if (word_off == APERSIZE'(STAT_OFF_LAST))  rd_dat_o = last_err_q;
  end

endmodule

// File: rtl/al4s3b_fpga_wb_decoder.sv
// rtl/al4s3b_fpga_wb_decoder.sv - Wishbone slave decoder with timeout and status aperture
module al4s3b_fpga_wb_decoder
  import al4s3b_fpga_wb_pkg::*;
#(
  parameter int                              NUM_SLAVES          = 4,
  parameter int                              APERWIDTH           = 17,
  parameter int                              APERSIZE            = 10,
  parameter logic [NUM_SLAVES*APERWIDTH-1:0] BASE_ADDRS          = {17'h04000, 17'h03000, 17'h02000, 17'h01000},
  parameter logic [APERWIDTH-1:0]            STATUS_BASE_ADDRESS = 17'h06000,
  parameter logic [31:0]                     DEFAULT_READ_VALUE  = 32'hBADFABAC,
  parameter int                              TIMEOUT_CYCLES      = 15
) (
  input  logic                       WBs_CLK_i,
  input  logic                       WBs_RST_n_i,
  input  logic [APERWIDTH-1:0]       WBs_ADR_i,
  input  logic                       WBs_CYC_i,
  input  logic                       WBs_STB_i,
  input  logic                       WBs_WE_i,
  input  logic [3:0]                 WBs_BYTE_STB_i,
  input  logic [31:0]                WBs_DAT_i,
  output logic [31:0]                WBs_RD_DAT_o,
  output logic                       WBs_ACK_o,
  output logic [NUM_SLAVES-1:0]      WBs_CYC_o,
  input  logic [NUM_SLAVES-1:0]      WBs_ACK_i,
  input  logic [NUM_SLAVES*32-1:0]   WBs_DAT_i_slv,
  output logic                       Bus_Err_o
);

  localparam int SIDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TAG_W  = APERWIDTH - APERSIZE;

  logic                  rst_meta_q, rst_sync_n_q;
  logic                  req, st_hit, slv_hit, slv_ack, tout_hit;
  logic                  unmap_evt, tout_evt, st_wr;
  logic [SIDX_W-1:0]     sel_idx;
  logic [NUM_SLAVES-1:0] sel;
  logic [31:0]           slv_dat, st_rd_dat, st_rd_q;
  logic [TOUT_CNT_W-1:0] tcnt_q;
  wb_state_e             state_q;
  logic                  unused_wdat;

  assign unused_wdat = ^WBs_DAT_i;

  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      rst_meta_q   <= 1'b0;
      rst_sync_n_q <= 1'b0;
    end else begin
      rst_meta_q   <= 1'b1;
      rst_sync_n_q <= rst_meta_q;
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    st_hit  = (WBs_ADR_i[APERWIDTH-1:APERSIZE] == STATUS_BASE_ADDRESS[APERWIDTH-1:APERSIZE]);
    slv_hit = 1'b0;
    sel_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (!st_hit && WBs_ADR_i[APERWIDTH-1:APERSIZE] == BASE_ADDRS[i*APERWIDTH+APERSIZE +: TAG_W]) begin
        slv_hit = 1'b1;
        sel_idx = SIDX_W'(i);
      end
    end
  end

  assign sel       = slv_hit ? (NUM_SLAVES'(1) << sel_idx) : '0;
  assign WBs_CYC_o = sel & {NUM_SLAVES{WBs_CYC_i}};
  assign req       = WBs_CYC_i & WBs_STB_i;
  assign slv_ack   = rst_sync_n_q & req & slv_hit & WBs_ACK_i[sel_idx];
  assign slv_dat   = WBs_DAT_i_slv[32*int'(sel_idx) +: 32];
  assign tout_hit  = ((tcnt_q + 1'b1) == TOUT_CNT_W'(TIMEOUT_CYCLES));

  assign unmap_evt = (state_q == S_IDLE) & req & ~st_hit & ~slv_hit;
  assign tout_evt  = (state_q == S_WAIT) & req & ~slv_ack & tout_hit;
  assign st_wr     = (state_q == S_IDLE) & req & st_hit & WBs_WE_i & (|WBs_BYTE_STB_i);

  al4s3b_fpga_wb_status_regs #(
    .APERWIDTH          (APERWIDTH),
    .APERSIZE           (APERSIZE),
    .DEFAULT_READ_VALUE (DEFAULT_READ_VALUE)
  ) u_status (
    .clk_i       (WBs_CLK_i),
    .rst_n_i     (rst_sync_n_q),
    .wr_i        (st_wr),
    .unmap_err_i (unmap_evt),
    .tout_err_i  (tout_evt),
    .err_adr_i   (WBs_ADR_i),
    .off_i       (WBs_ADR_i[APERSIZE-1:0]),
    .rd_dat_o    (st_rd_dat)
  );

  always_ff @(posedge WBs_CLK_i or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      st_rd_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (st_hit) begin
              state_q <= S_ST_ACK;
              st_rd_q <= st_rd_dat;
            end else if (!slv_hit) begin
              state_q <= S_ERR_ACK;
            end else if (!slv_ack) begin
              state_q <= S_WAIT;
              tcnt_q  <= '0;
            end
          end
        end
        S_WAIT: begin
          if (slv_ack || !req) state_q <= S_IDLE;
          else if (tout_hit)   state_q <= S_ERR_ACK;
          else                 tcnt_q  <= tcnt_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    WBs_ACK_o    = 1'b0;
    Bus_Err_o    = 1'b0;
    WBs_RD_DAT_o = DEFAULT_READ_VALUE;
    case (state_q)
      S_ERR_ACK: begin
        WBs_ACK_o = 1'b1;
        Bus_Err_o = 1'b1;
      end
      S_ST_ACK: begin
        WBs_ACK_o    = 1'b1;
        WBs_RD_DAT_o = st_rd_q;
      end
      default: begin
        WBs_ACK_o = slv_ack;
        if (slv_hit) WBs_RD_DAT_o = slv_dat;
      end
    endcase
  end

endmodule
